// File: rtl/gf180_ram_512x32_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gf180_ram_512x32_arbiter
//  Purpose  : Round-robin two-port arbiter and fixed three-cycle sequencer
//             for the single-port GF180_RAM_512x32 macro.
//             - Port 0 is the CPU side and port 1 is the DMA side.
//             - All RAM controls (active low) come from registers.
//             - Read data returns with a one-cycle ready pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module gf180_ram_512x32_arbiter #(
   parameter int AW = 9,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            resetn,
   // Port 0 (CPU / Wishbone adapter)
   input  logic            p0_valid,
   input  logic [AW-1:0]   p0_addr,
   input  logic [DW-1:0]   p0_wdata,
   input  logic [DW/8-1:0] p0_wstrb,
   output logic            p0_ready,
   output logic [DW-1:0]   p0_rdata,
   // Port 1 (DMA / housekeeping)
   input  logic            p1_valid,
   input  logic [AW-1:0]   p1_addr,
   input  logic [DW-1:0]   p1_wdata,
   input  logic [DW/8-1:0] p1_wstrb,
   output logic            p1_ready,
   output logic [DW-1:0]   p1_rdata,
   // Status
   output logic            busy,
   output logic            gnt_id,
   // RAM macro side
   output logic            ram_cen,
   output logic            ram_gwen,
   output logic [DW/8-1:0] ram_wen,
   output logic [AW-1:0]   ram_a,
   output logic [DW-1:0]   ram_d,
   input  logic [DW-1:0]   ram_q
);

   localparam int c_NB = DW / 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------
   state_t            r_state;
   logic              r_last_gnt;
   logic              r_gnt_id;
   logic              r_ram_cen;
   logic              r_ram_gwen;
   logic [c_NB-1:0]   r_ram_wen;
   logic [AW-1:0]     r_ram_a;
   logic [DW-1:0]     r_ram_d;
   logic              r_p0_ready;
   logic              r_p1_ready;

   // ------------------------------------------------------------------
   // Next-state values
   // ------------------------------------------------------------------
   state_t            w_state_nxt;
   logic              w_last_gnt_nxt;
   logic              w_gnt_id_nxt;
   logic              w_ram_cen_nxt;
   logic              w_ram_gwen_nxt;
   logic [c_NB-1:0]   w_ram_wen_nxt;
   logic [AW-1:0]     w_ram_a_nxt;
   logic [DW-1:0]     w_ram_d_nxt;
   logic              w_p0_ready_nxt;
   logic              w_p1_ready_nxt;

   // ------------------------------------------------------------------
   // Arbitration outputs
   // ------------------------------------------------------------------
   logic              w_req_any;
   logic              w_winner;
   logic [AW-1:0]     w_sel_addr;
   logic [DW-1:0]     w_sel_wdata;
   logic [c_NB-1:0]   w_sel_wstrb;
   logic              w_sel_is_read;

   // Round-robin pick: a lone requester wins, a tie goes to the port that
   // did not win last time so neither side can be starved.
   always_comb begin
      w_req_any = p0_valid | p1_valid;
      if (p0_valid && p1_valid) begin
         w_winner = ~r_last_gnt;
      end else begin
         w_winner = p1_valid;
      end
      w_sel_addr    = w_winner ? p1_addr  : p0_addr;
      w_sel_wdata   = w_winner ? p1_wdata : p0_wdata;
      w_sel_wstrb   = w_winner ? p1_wstrb : p0_wstrb;
      w_sel_is_read = (w_sel_wstrb == '0);
   end

   // Sequencer: IDLE launches the access, ACCESS lets the RAM sample and
   // raises ready, RESP holds ready for one cycle. Only IDLE arbitrates,
   // because the requester still shows its old valid during RESP.
   always_comb begin
      w_state_nxt    = r_state;
      w_last_gnt_nxt = r_last_gnt;
      w_gnt_id_nxt   = r_gnt_id;
      w_ram_cen_nxt  = 1'b1;
      w_ram_gwen_nxt = 1'b1;
      w_ram_wen_nxt  = '1;
      w_ram_a_nxt    = r_ram_a;
      w_ram_d_nxt    = r_ram_d;
      w_p0_ready_nxt = 1'b0;
      w_p1_ready_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_req_any) begin
               w_state_nxt    = ST_ACCESS;
               w_ram_cen_nxt  = 1'b0;
               w_ram_a_nxt    = w_sel_addr;
               w_ram_d_nxt    = w_sel_wdata;
               // A read leaves every byte enable deasserted (all ones).
               w_ram_gwen_nxt = w_sel_is_read;
               w_ram_wen_nxt  = ~w_sel_wstrb;
               w_gnt_id_nxt   = w_winner;
               w_last_gnt_nxt = w_winner;
            end
         end

         ST_ACCESS: begin
            // Controls drop back to inactive; address/data simply hold.
            w_state_nxt    = ST_RESP;
            w_p0_ready_nxt = (r_gnt_id == 1'b0);
            w_p1_ready_nxt = (r_gnt_id == 1'b1);
         end

         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered RAM controls, grant bookkeeping and ready pulses.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_last_gnt <= 1'b1;          // port 0 wins the first tie
         r_gnt_id   <= 1'b0;
         r_ram_cen  <= 1'b1;
         r_ram_gwen <= 1'b1;
         r_ram_wen  <= '1;
         r_ram_a    <= '0;
         r_ram_d    <= '0;
         r_p0_ready <= 1'b0;
         r_p1_ready <= 1'b0;
      end else begin
         r_last_gnt <= w_last_gnt_nxt;
         r_gnt_id   <= w_gnt_id_nxt;
         r_ram_cen  <= w_ram_cen_nxt;
         r_ram_gwen <= w_ram_gwen_nxt;
         r_ram_wen  <= w_ram_wen_nxt;
         r_ram_a    <= w_ram_a_nxt;
         r_ram_d    <= w_ram_d_nxt;
         r_p0_ready <= w_p0_ready_nxt;
         r_p1_ready <= w_p1_ready_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Outputs. Read data is a straight fan-out of the RAM Q bus; each
   // requester only looks at it while its own ready is high.
   // ------------------------------------------------------------------
   assign p0_ready = r_p0_ready;
   assign p1_ready = r_p1_ready;
   assign p0_rdata = ram_q;
   assign p1_rdata = ram_q;
   assign busy     = (r_state != ST_IDLE);
   assign gnt_id   = r_gnt_id;
   assign ram_cen  = r_ram_cen;
   assign ram_gwen = r_ram_gwen;
   assign ram_wen  = r_ram_wen;
   assign ram_a    = r_ram_a;
   assign ram_d    = r_ram_d;

endmodule
`default_nettype wire

// File: tb/tb_gf180_ram_512x32_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gf180_ram_512x32_arbiter
//  Purpose  : Scoreboard bench for the RAM arbiter with a behavioural RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gf180_ram_512x32_arbiter;

   localparam int AW = 9;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            p0_valid = 1'b0, p1_valid = 1'b0;
   logic [AW-1:0]   p0_addr = '0, p1_addr = '0;
   logic [DW-1:0]   p0_wdata = '0, p1_wdata = '0;
   logic [3:0]      p0_wstrb = '0, p1_wstrb = '0;
   logic            p0_ready, p1_ready;
   logic [DW-1:0]   p0_rdata, p1_rdata;
   logic            busy, gnt_id;
   logic            ram_cen, ram_gwen;
   logic [3:0]      ram_wen;
   logic [AW-1:0]   ram_a;
   logic [DW-1:0]   ram_d;
   logic [DW-1:0]   ram_q = '0;

   gf180_ram_512x32_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .resetn(resetn),
      .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_wstrb(p0_wstrb), .p0_ready(p0_ready), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_wstrb(p1_wstrb), .p1_ready(p1_ready), .p1_rdata(p1_rdata),
      .busy(busy), .gnt_id(gnt_id),
      .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen),
      .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM: samples on the clock edge, Q the cycle after.
   logic [DW-1:0] ram_mem [0:511];
   always @(posedge clk) begin
      if (!ram_cen) begin
         if (!ram_gwen) begin
            for (int b = 0; b < 4; b++)
               if (!ram_wen[b]) ram_mem[ram_a][b*8 +: 8] <= ram_d[b*8 +: 8];
         end
         ram_q <= ram_mem[ram_a];
      end
   end

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          gwen;
      logic [3:0]    wen;
      logic          rd;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t          q0[$];
   exp_t          q1[$];
   int            gq[$];
   logic [DW-1:0] exp_mem [0:511];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Snapshot of the last ACCESS cycle seen on the RAM pins
   logic [AW-1:0] acc_a;
   logic [DW-1:0] acc_d;
   logic          acc_gwen;
   logic [3:0]    acc_wen;
   int            acc_cyc = -100;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic score(input bit port);
      exp_t e;
      if ((port ? q1.size() : q0.size()) == 0) begin
         check("unexpected_ready", 64'(port), 64'hFF);
      end else begin
         e = port ? q1.pop_front() : q0.pop_front();
         check("gnt_id", 64'(gnt_id), 64'(port));
         check("ram_a", 64'(acc_a), 64'(e.a));
         check("ram_d", 64'(acc_d), 64'(e.d));
         check("ram_gwen", 64'(acc_gwen), 64'(e.gwen));
         check("ram_wen", 64'(acc_wen), 64'(e.wen));
         check("ready_lat", 64'(cyc - acc_cyc + 1), 64'd2);
         check("cen_released", 64'(ram_cen), 64'd1);
         if (e.rd) check("rdata", 64'(port ? p1_rdata : p0_rdata), 64'(e.rdata));
         if (gq.size() > 0) check("gnt_order", 64'(port), 64'(gq.pop_front()));
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: record the access cycle, score every ready pulse.
   initial forever begin
      @(negedge clk);
      if (resetn) begin
         if (!ram_cen) begin
            acc_a    = ram_a;
            acc_d    = ram_d;
            acc_gwen = ram_gwen;
            acc_wen  = ram_wen;
            acc_cyc  = cyc;
         end
         if (p0_ready && p1_ready) check("dual_ready", 64'd1, 64'd0);
         if (p0_ready) score(1'b0);
         if (p1_ready) score(1'b1);
      end
   end

   // Drive one request on a port, push its expectation, wait for ready.
   // Called just after a rising edge; returns just after the next one.
   task automatic do_req(input bit port, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [3:0] wstrb,
                         input bit chk_lat, output int rdy_cyc);
      exp_t e;
      int   start;
      bit   got;
      e.a     = addr;
      e.d     = wdata;
      e.gwen  = (wstrb == 4'h0);
      e.wen   = ~wstrb;
      e.rd    = (wstrb == 4'h0);
      e.rdata = exp_mem[addr];
      for (int b = 0; b < 4; b++)
         if (wstrb[b]) exp_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
      if (port) begin
         p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb; p1_valid = 1'b1;
         q1.push_back(e);
      end else begin
         p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb; p0_valid = 1'b1;
         q0.push_back(e);
      end
      start = cyc;
      got   = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (port ? p1_ready : p0_ready) got = 1'b1;
      end
      rdy_cyc = cyc;
      if (!got) check("ready_timeout", 64'd0, 64'd1);
      else if (chk_lat) check("req_latency", 64'(rdy_cyc - start), 64'd2);
      @(posedge clk);
      #1;
      if (port) p1_valid = 1'b0;
      else      p0_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, c0, r1, r2, r3;
      for (int i = 0; i < 512; i++) begin
         ram_mem[i] = '0;
         exp_mem[i] = '0;
      end

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_cen", 64'(ram_cen), 64'd1);
      check("rst_gwen", 64'(ram_gwen), 64'd1);
      check("rst_wen", 64'(ram_wen), 64'hF);
      check("rst_a", 64'(ram_a), 64'd0);
      check("rst_d", 64'(ram_d), 64'd0);
      check("rst_p0_ready", 64'(p0_ready), 64'd0);
      check("rst_p1_ready", 64'(p1_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_gnt", 64'(gnt_id), 64'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Port 0 full write then read back
      do_req(1'b0, 9'h005, 32'hDEADBEEF, 4'hF, 1'b1, r);
      do_req(1'b0, 9'h005, 32'h0, 4'h0, 1'b1, r);

      // Byte-lane write at the top address
      do_req(1'b0, 9'h1FF, 32'h11223344, 4'hF, 1'b1, r);
      do_req(1'b1, 9'h1FF, 32'hAABBCCDD, 4'h5, 1'b1, r);
      do_req(1'b0, 9'h1FF, 32'h0, 4'h0, 1'b1, r);
      check("byte_merge_model", 64'(exp_mem[9'h1FF]), 64'h11BB33DD);

      // Port 1 alone, three back-to-back reads
      c0 = cyc;
      do_req(1'b1, 9'h005, 32'h0, 4'h0, 1'b1, r1);
      do_req(1'b1, 9'h1FF, 32'h0, 4'h0, 1'b1, r2);
      do_req(1'b1, 9'h000, 32'h0, 4'h0, 1'b1, r3);
      check("p1_ready_c1", 64'(r1 - c0), 64'd2);
      check("p1_ready_c2", 64'(r2 - c0), 64'd5);
      check("p1_ready_c3", 64'(r3 - c0), 64'd8);

      // Both ports contending: grants must alternate 0,1,0,1,...
      // Reset first so the tie-break starts from its reset value.
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) gq.push_back(i % 2);
      fork
         begin
            int rr;
            do_req(1'b0, 9'h010, 32'hA0A0A0A0, 4'hF, 1'b0, rr);
            do_req(1'b0, 9'h010, 32'h0, 4'h0, 1'b0, rr);
            do_req(1'b0, 9'h011, 32'h01234567, 4'hC, 1'b0, rr);
            do_req(1'b0, 9'h011, 32'h0, 4'h0, 1'b0, rr);
         end
         begin
            int rr;
            do_req(1'b1, 9'h020, 32'hB1B2B3B4, 4'hF, 1'b0, rr);
            do_req(1'b1, 9'h020, 32'h0, 4'h0, 1'b0, rr);
            do_req(1'b1, 9'h021, 32'h89ABCDEF, 4'h3, 1'b0, rr);
            do_req(1'b1, 9'h021, 32'h0, 4'h0, 1'b0, rr);
         end
      join
      check("gnt_queue_drained", 64'(gq.size()), 64'd0);

      // Reset in the middle of a port 0 write
      p0_addr = 9'h0A0; p0_wdata = 32'h5A5A1234; p0_wstrb = 4'hF; p0_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("mid_pre_cen", 64'(ram_cen), 64'd0);
      #1 resetn = 1'b0;
      #1;
      check("mid_cen", 64'(ram_cen), 64'd1);
      check("mid_gwen", 64'(ram_gwen), 64'd1);
      check("mid_wen", 64'(ram_wen), 64'hF);
      check("mid_p0_ready", 64'(p0_ready), 64'd0);
      check("mid_busy", 64'(busy), 64'd0);
      check("mid_gnt", 64'(gnt_id), 64'd0);
      p0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_no_ready", 64'(p0_ready), 64'd0);
         check("post_rst_idle", 64'(busy), 64'd0);
      end
      @(posedge clk); #1;
      do_req(1'b0, 9'h0A0, 32'h5A5A1234, 4'hF, 1'b1, r);
      do_req(1'b0, 9'h0A0, 32'h0, 4'h0, 1'b1, r);

      // Idle: nothing requested for 20 cycles
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_cen", 64'(ram_cen), 64'd1);
         check("idle_busy", 64'(busy), 64'd0);
      end
      check("q0_drained", 64'(q0.size()), 64'd0);
      check("q1_drained", 64'(q1.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
